// File: rtl/ptp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ptp_pkg
//  Description : Shared definitions for the ptp packer/unpacker family:
//                default widths, state encoding, clog2 and slot offset helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ptp_pkg;

   localparam int DEF_IN_W  = 8;
   localparam int DEF_OUT_W = 32;

   // Output-register occupancy; the fill count is tracked separately
   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ptp_state_t;

   // Ceiling log2, with clog2(1) = 0
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Lowest bit position of slot k inside a wide word
   function automatic int slot_lo(input int k, input int in_w, input int out_w,
                                  input bit msb_first);
      return msb_first ? (out_w - (k + 1) * in_w) : (k * in_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ptp_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ptp_pack
//  Description : Narrow-to-wide packer. Gathers IN_W-bit chunks over a
//                valid/ready input into OUT_W-bit words held in a one-word
//                output register, sustaining one chunk per cycle.
//                Optional partial-word flush: define PTP_PACK_FLUSH_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module ptp_pack
   import ptp_pkg::*;
#(
   parameter int IN_W      = DEF_IN_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter bit MSB_FIRST = 1'b1,
   localparam int c_n      = OUT_W / IN_W,
   localparam int c_fw     = clog2(c_n) + 1
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   input  logic [IN_W-1:0]   in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [OUT_W-1:0]  out_data_o,
   input  logic              out_ready_i,
`ifdef PTP_PACK_FLUSH_EN
   input  logic              flush_i,
   output logic [c_fw-1:0]   out_count_o,
`endif
   output logic [c_fw-1:0]   fill_o
);

   localparam logic [c_fw-1:0] c_last = c_fw'(c_n - 1);

   if (OUT_W % IN_W != 0) begin : g_width_check
      $error("ptp_pack: OUT_W must be a multiple of IN_W");
   end

   ptp_state_t         r_state, w_state_nxt;
   logic [c_fw-1:0]    r_fill, w_fill_nxt;
   logic [OUT_W-1:0]   r_acc, w_acc_nxt, w_acc_wr;
   logic [OUT_W-1:0]   r_out, w_out_nxt;
   logic               w_out_free, w_out_xfer, w_in_ready, w_in_xfer;
   logic               w_complete, w_load;
`ifdef PTP_PACK_FLUSH_EN
   logic [c_fw-1:0]    r_count, w_count_nxt;
   logic               w_flush, w_flush_blocked;
`endif

   // State register: output word, accumulator and fill count
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state <= EMPTY;
         r_fill  <= '0;
         r_acc   <= '0;
         r_out   <= '0;
`ifdef PTP_PACK_FLUSH_EN
         r_count <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_fill  <= w_fill_nxt;
         r_acc   <= w_acc_nxt;
         r_out   <= w_out_nxt;
`ifdef PTP_PACK_FLUSH_EN
         r_count <= w_count_nxt;
`endif
      end
   end

   // Handshakes, chunk insertion and next-state selection
   always_comb begin
      w_out_xfer = (r_state == FULL) && out_ready_i;
      w_out_free = (r_state == EMPTY) || out_ready_i;
      // Only the final chunk has to wait for a free output register
      w_in_ready = !((r_fill == c_last) && (r_state == FULL) && !out_ready_i);
`ifdef PTP_PACK_FLUSH_EN
      w_flush_blocked = flush_i && (r_fill != '0) && !w_out_free;
      w_in_ready      = w_in_ready && !w_flush_blocked;
`endif
      w_in_xfer  = in_valid_i && w_in_ready;
      w_complete = w_in_xfer && (r_fill == c_last);

      w_acc_wr = r_acc;
      for (int k = 0; k < c_n; k++) begin
         if (w_in_xfer && (r_fill == c_fw'(k))) begin
            w_acc_wr[slot_lo(k, IN_W, OUT_W, MSB_FIRST) +: IN_W] = in_data_i;
         end
      end

`ifdef PTP_PACK_FLUSH_EN
      // A chunk arriving with the flush is folded in before the word leaves
      w_flush = flush_i && w_out_free && !w_complete && ((r_fill != '0) || w_in_xfer);
      w_load  = w_complete || w_flush;
`else
      w_load  = w_complete;
`endif

      w_state_nxt = r_state;
      w_fill_nxt  = r_fill;
      w_acc_nxt   = r_acc;
      w_out_nxt   = r_out;
`ifdef PTP_PACK_FLUSH_EN
      w_count_nxt = r_count;
`endif

      if (w_in_xfer) begin
         w_acc_nxt  = w_acc_wr;
         w_fill_nxt = r_fill + c_fw'(1);
      end

      if (w_load) begin
         w_out_nxt   = w_acc_wr;
         w_acc_nxt   = '0;
         w_fill_nxt  = '0;
         w_state_nxt = FULL;
`ifdef PTP_PACK_FLUSH_EN
         w_count_nxt = w_complete ? c_fw'(c_n) : (r_fill + c_fw'(w_in_xfer));
`endif
      end else if (w_out_xfer) begin
         w_state_nxt = EMPTY;
      end
   end

   assign in_ready_o  = w_in_ready;
   assign out_valid_o = (r_state == FULL);
   assign out_data_o  = r_out;
   assign fill_o      = r_fill;
`ifdef PTP_PACK_FLUSH_EN
   assign out_count_o = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ptp_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ptp_pack
//  Description : Directed, table-driven bench for ptp_pack. One MSB-first and
//                one LSB-first instance share the same stimulus.
//                Flush sequence compiled in with PTP_PACK_FLUSH_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ptp_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_ready;
   logic        flush;

   logic        ir_m, ov_m, ir_l, ov_l;
   logic [31:0] od_m, od_l;
   logic [2:0]  fill_m, fill_l;
   logic [2:0]  cnt_m, cnt_l;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ptp_pack #(.IN_W(8), .OUT_W(32), .MSB_FIRST(1'b1)) u_msb (
      .clock_i     (clk),
      .reset_i     (rst),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (ir_m),
      .out_valid_o (ov_m),
      .out_data_o  (od_m),
      .out_ready_i (out_ready),
`ifdef PTP_PACK_FLUSH_EN
      .flush_i     (flush),
      .out_count_o (cnt_m),
`endif
      .fill_o      (fill_m)
   );

   ptp_pack #(.IN_W(8), .OUT_W(32), .MSB_FIRST(1'b0)) u_lsb (
      .clock_i     (clk),
      .reset_i     (rst),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (ir_l),
      .out_valid_o (ov_l),
      .out_data_o  (od_l),
      .out_ready_i (out_ready),
`ifdef PTP_PACK_FLUSH_EN
      .flush_i     (flush),
      .out_count_o (cnt_l),
`endif
      .fill_o      (fill_l)
   );

`ifndef PTP_PACK_FLUSH_EN
   assign cnt_m = '0;
   assign cnt_l = '0;
`endif

   typedef struct {
      logic        rst;
      logic        vld;
      logic [7:0]  din;
      logic        rdy;
      logic        exp_ir;
      logic        exp_ov;
      logic [31:0] exp_m;
      logic [31:0] exp_l;
      logic [2:0]  exp_fill;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic v, input logic [7:0] d,
                               input logic rd, input logic eir, input logic eov,
                               input logic [31:0] em, input logic [31:0] el,
                               input logic [2:0] ef);
      vec_t t;
      t.rst = r; t.vld = v; t.din = d; t.rdy = rd;
      t.exp_ir = eir; t.exp_ov = eov; t.exp_m = em; t.exp_l = el; t.exp_fill = ef;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle, check in_ready before the edge and the rest after it
   task automatic apply(input vec_t t, input int idx);
      rst       = t.rst;
      in_valid  = t.vld;
      in_data   = t.din;
      out_ready = t.rdy;
      #3;
      check("in_ready_msb", idx, {31'd0, ir_m}, {31'd0, t.exp_ir});
      check("in_ready_lsb", idx, {31'd0, ir_l}, {31'd0, t.exp_ir});
      @(posedge clk);
      #1;
      check("out_valid", idx, {31'd0, ov_m}, {31'd0, t.exp_ov});
      check("out_valid_lsb", idx, {31'd0, ov_l}, {31'd0, t.exp_ov});
      check("out_data_msb", idx, od_m, t.exp_m);
      check("out_data_lsb", idx, od_l, t.exp_l);
      check("fill", idx, {29'd0, fill_m}, {29'd0, t.exp_fill});
   endtask

   initial begin
      logic [31:0] hm;
      logic [31:0] hl;
      logic [7:0]  b;
      vec_t        t;

      // Basic word, ready always high; valid for exactly one cycle
      add(0, 1, 8'h12, 1, 1, 0, 32'h0, 32'h0, 3'd1);
      add(0, 1, 8'h34, 1, 1, 0, 32'h0, 32'h0, 3'd2);
      add(0, 1, 8'h56, 1, 1, 0, 32'h0, 32'h0, 3'd3);
      add(0, 1, 8'h78, 1, 1, 1, 32'h12345678, 32'h78563412, 3'd0);
      add(0, 0, 8'hEE, 1, 1, 0, 32'h12345678, 32'h78563412, 3'd0);
      // Back-pressure: eight chunks with the consumer stalled
      add(0, 1, 8'h01, 0, 1, 0, 32'h12345678, 32'h78563412, 3'd1);
      add(0, 1, 8'h02, 0, 1, 0, 32'h12345678, 32'h78563412, 3'd2);
      add(0, 1, 8'h03, 0, 1, 0, 32'h12345678, 32'h78563412, 3'd3);
      add(0, 1, 8'h04, 0, 1, 1, 32'h01020304, 32'h04030201, 3'd0);
      add(0, 1, 8'h05, 0, 1, 1, 32'h01020304, 32'h04030201, 3'd1);
      add(0, 1, 8'h06, 0, 1, 1, 32'h01020304, 32'h04030201, 3'd2);
      add(0, 1, 8'h07, 0, 1, 1, 32'h01020304, 32'h04030201, 3'd3);
      add(0, 1, 8'h08, 0, 0, 1, 32'h01020304, 32'h04030201, 3'd3);
      add(0, 1, 8'h08, 0, 0, 1, 32'h01020304, 32'h04030201, 3'd3);
      add(0, 1, 8'h08, 1, 1, 1, 32'h05060708, 32'h08070605, 3'd0);
      add(0, 0, 8'h00, 1, 1, 0, 32'h05060708, 32'h08070605, 3'd0);
      // Continuous stream 0x00..0x0F, a word every fourth cycle
      hm = 32'h05060708;
      hl = 32'h08070605;
      for (int i = 0; i < 16; i++) begin
         b = 8'(i);
         if (i % 4 == 3) begin
            hm = {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)};
            hl = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
         end
         add(0, 1, b, 1, 1, (i % 4 == 3), hm, hl, 3'((i + 1) % 4));
      end
      add(0, 0, 8'h00, 1, 1, 0, 32'h0C0D0E0F, 32'h0F0E0D0C, 3'd0);
      // Reset mid-word, with a concurrent chunk offered
      add(0, 1, 8'h99, 1, 1, 0, 32'h0C0D0E0F, 32'h0F0E0D0C, 3'd1);
      add(0, 1, 8'h98, 1, 1, 0, 32'h0C0D0E0F, 32'h0F0E0D0C, 3'd2);
      add(1, 1, 8'h97, 1, 1, 0, 32'h0, 32'h0, 3'd0);
      add(0, 1, 8'hAA, 1, 1, 0, 32'h0, 32'h0, 3'd1);
      add(0, 1, 8'hBB, 1, 1, 0, 32'h0, 32'h0, 3'd2);
      add(0, 1, 8'hCC, 1, 1, 0, 32'h0, 32'h0, 3'd3);
      add(0, 1, 8'hDD, 1, 1, 1, 32'hAABBCCDD, 32'hDDCCBBAA, 3'd0);
      add(0, 0, 8'h00, 1, 1, 0, 32'hAABBCCDD, 32'hDDCCBBAA, 3'd0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", -1, {31'd0, ov_m}, 32'd0);
      check("reset_out_data", -1, od_m, 32'd0);
      check("reset_fill", -1, {29'd0, fill_m}, 32'd0);
      check("reset_out_data_lsb", -1, od_l, 32'd0);
`ifdef PTP_PACK_FLUSH_EN
      check("reset_out_count", -1, {29'd0, cnt_m}, 32'd0);
`endif
      rst = 1'b0;
      #1;
      check("reset_in_ready", -1, {31'd0, ir_m}, 32'd1);

      foreach (vecs[i]) begin
         t = vecs[i];
         apply(t, i);
      end

`ifdef PTP_PACK_FLUSH_EN
      // Partial word flush, then a full word reports four chunks
      add(0, 1, 8'h11, 1, 1, 0, 32'hAABBCCDD, 32'hDDCCBBAA, 3'd1);
      add(0, 1, 8'h22, 1, 1, 0, 32'hAABBCCDD, 32'hDDCCBBAA, 3'd2);
      t = vecs[vecs.size() - 2];
      apply(t, 100);
      t = vecs[vecs.size() - 1];
      apply(t, 101);
      flush = 1'b1;
      t.vld = 1'b0; t.exp_ir = 1'b1; t.exp_ov = 1'b1;
      t.exp_m = 32'h11220000; t.exp_l = 32'h00002211; t.exp_fill = 3'd0;
      apply(t, 102);
      flush = 1'b0;
      check("flush_count_msb", 102, {29'd0, cnt_m}, 32'd2);
      check("flush_count_lsb", 102, {29'd0, cnt_l}, 32'd2);
      for (int i = 1; i <= 4; i++) begin
         t.vld = 1'b1; t.din = 8'(i); t.rdy = 1'b1; t.exp_ir = 1'b1;
         t.exp_ov = (i == 4);
         t.exp_m = (i == 4) ? 32'h01020304 : 32'h11220000;
         t.exp_l = (i == 4) ? 32'h04030201 : 32'h00002211;
         t.exp_fill = 3'(i % 4);
         apply(t, 102 + i);
      end
      check("full_count", 106, {29'd0, cnt_m}, 32'd4);
`else
      cnt_chk: begin
         check("count_tied", 200, {29'd0, cnt_m}, {29'd0, cnt_l});
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
